vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the pixel clock: pixel coordinates, active-video flag, and active-low horizontal/vertical sync. It drives the `DrawX`/`DrawY`/`blank` inputs of every pixel-producing block (menu, game screens, sprite renderers) and the `hsync`/`vsync` pins of the VGA connector. All outputs come from one counter state, so coordinates, `blank` and syncs are mutually aligned on every cycle.

---
 rtl/vga_timing_gen_if.sv | 20 ++
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to its pixel consumers and the VGA connector.
// frame_count exists only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        hsync;
  logic        vsync;
  logic        line_start;
  logic        frame_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count;

  modport master (output DrawX, DrawY, blank, hsync, vsync, line_start, frame_start, frame_count);
  modport slave  (input  DrawX, DrawY, blank, hsync, vsync, line_start, frame_start, frame_count);
`else
  modport master (output DrawX, DrawY, blank, hsync, vsync, line_start, frame_start);
  modport slave  (input  DrawX, DrawY, blank, hsync, vsync, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: registered coordinates, blank, active-low syncs and line/frame pulses.
// Optional frame counter enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_cfg
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  logic [9:0] h_q, h_d, v_q, v_d;
  logic       blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;
  logic       ls_q, ls_d, fs_q, fs_d;
  logic       h_wrap;

  // Outputs are decoded from the next counter value so every registered
  // output lines up with the coordinates shown in the same cycle.
  always_comb begin
    h_wrap  = (h_q == H_LAST);
    h_d     = h_wrap ? '0 : h_q + 10'd1;
    v_d     = v_q;
    if (h_wrap) v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    blank_d = (int'(h_d) < H_VISIBLE) && (int'(v_d) < V_VISIBLE);
    hs_d    = !((int'(h_d) >= HS_START) && (int'(h_d) < HS_END));
    vs_d    = !((int'(v_d) >= VS_START) && (int'(v_d) < VS_END));
    ls_d    = (h_d == '0);
    fs_d    = ls_d && (v_d == '0);
  end

  // Reset parks on the last back-porch pixel so release lands on (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  assign vga.DrawX       = h_q;
  assign vga.DrawY       = v_q;
  assign vga.blank       = blank_q;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        seen_q;

  // The first frame_start after reset opens frame 0; later ones count completions.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (fs_d && seen_q) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      seen_q      <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      seen_q      <= seen_q | fs_d;
    end
  end

  assign vga.frame_count = frame_cnt_q;
`else
  // Frame counter not built.
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line timing and a shrunk
// instance for frame-level behaviour, both checked against a position model.
module tb_vga_timing_gen;
  localparam int BHV = 16, BHF = 4, BHS = 6, BHB = 6;
  localparam int BVV = 12, BVF = 2, BVS = 2, BVB = 3;
  localparam longint BFT = 32 * 19;

  logic vga_clk = 1'b0;
  logic rst_a, rst_b;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();

  vga_timing_gen dut_a (.vga_clk(vga_clk), .reset_n(rst_a), .vga(if_a.master));
  vga_timing_gen #(
    .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
    .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB)
  ) dut_b (.vga_clk(vga_clk), .reset_n(rst_b), .vga(if_b.master));

  always #5 vga_clk = ~vga_clk;

  logic [24:0] oa, ob;
  assign oa = {if_a.DrawX, if_a.DrawY, if_a.blank, if_a.hsync, if_a.vsync, if_a.line_start, if_a.frame_start};
  assign ob = {if_b.DrawX, if_b.DrawY, if_b.blank, if_b.hsync, if_b.vsync, if_b.line_start, if_b.frame_start};

  int pass_cnt = 0, chk_cnt = 0;
  longint ka = 0, kb = 0;
  bit stats_on = 0, fc_track = 1;
  int a_blank_n = 0, a_hs_n = 0, a_hs_first = -1, a_hs_last = -1, b_vs_n = 0;
  longint b_fs_q[$];
  int b_fc_q[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Position after k clock edges since release (k = 0 is the held reset state).
  function automatic logic [24:0] model(int hv, int hf, int hs, int hb,
                                        int vv, int vf, int vs, int vb, longint k);
    int ht, vt, x, y;
    longint ft, p;
    logic bl, h, v, l, f;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    ft = longint'(ht) * vt;
    p  = (k == 0) ? ft - 1 : (k - 1) % ft;
    x  = int'(p % ht);
    y  = int'(p / ht);
    bl = (x < hv) && (y < vv);
    h  = !(x >= hv + hf && x < hv + hf + hs);
    v  = !(y >= vv + vf && y < vv + vf + vs);
    l  = (k != 0) && (x == 0);
    f  = l && (y == 0);
    return {10'(x), 10'(y), bl, h, v, l, f};
  endfunction

  function automatic logic [24:0] mA(longint k);
    return model(640, 16, 96, 48, 480, 10, 2, 33, k);
  endfunction

  function automatic logic [24:0] mB(longint k);
    return model(BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, k);
  endfunction

  function automatic logic [15:0] fcB(longint k);
    return (k == 0) ? 16'd0 : 16'((k - 1) / BFT);
  endfunction

  task automatic step();
    @(posedge vga_clk);
    @(negedge vga_clk);
    if (rst_a) ka++;
    if (rst_b) kb++;
    chk($sformatf("A_pos k=%0d", ka), 32'(oa), 32'(mA(ka)));
    chk($sformatf("B_pos k=%0d", kb), 32'(ob), 32'(mB(kb)));
`ifdef VGA_FRAME_COUNT_EN
    if (fc_track) chk($sformatf("B_fcnt k=%0d", kb), 32'(if_b.frame_count), 32'(fcB(kb)));
`endif
    if (stats_on) begin
      if (ka >= 1 && ka <= 800) begin
        if (if_a.blank) a_blank_n++;
        if (!if_a.hsync) begin
          a_hs_n++;
          if (a_hs_first < 0) a_hs_first = int'(if_a.DrawX);
          a_hs_last = int'(if_a.DrawX);
        end
      end
      if (kb >= 1 && kb <= BFT && !if_b.vsync) b_vs_n++;
      if (if_b.frame_start) begin
        b_fs_q.push_back(kb);
`ifdef VGA_FRAME_COUNT_EN
        b_fc_q.push_back(int'(if_b.frame_count));
`endif
      end
    end
  endtask

  // Reset asserted between clock edges; outputs must settle without any edge.
  task automatic async_rst(bit on_a, int d);
    #(d);
    if (on_a) begin
      rst_a = 1'b0;
      ka = 0;
      #1;
      chk("A_async_hsync", 32'(if_a.hsync), 32'd1);
      chk("A_async_vsync", 32'(if_a.vsync), 32'd1);
      chk("A_async_pos", 32'({if_a.DrawX, if_a.DrawY}), 32'({10'd799, 10'd524}));
      chk("A_async_blank", 32'(if_a.blank), 32'd0);
    end else begin
      rst_b = 1'b0;
      kb = 0;
      #1;
      chk("B_async_hsync", 32'(if_b.hsync), 32'd1);
      chk("B_async_vsync", 32'(if_b.vsync), 32'd1);
      chk("B_async_pos", 32'({if_b.DrawX, if_b.DrawY}), 32'({10'd31, 10'd18}));
      chk("B_async_blank", 32'(if_b.blank), 32'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [24:0] m;
    bit found;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) @(posedge vga_clk);
    @(negedge vga_clk);
    chk("rst_DrawX", 32'(if_a.DrawX), 32'd799);
    chk("rst_DrawY", 32'(if_a.DrawY), 32'd524);
    chk("rst_blank", 32'(if_a.blank), 32'd0);
    chk("rst_hsync", 32'(if_a.hsync), 32'd1);
    chk("rst_vsync", 32'(if_a.vsync), 32'd1);
    chk("rst_pulses", 32'({if_a.line_start, if_a.frame_start}), 32'd0);
    chk("rst_B_pos", 32'({if_b.DrawX, if_b.DrawY}), 32'({10'd31, 10'd18}));
`ifdef VGA_FRAME_COUNT_EN
    chk("rst_fcnt", 32'(if_b.frame_count), 32'd0);
`endif

    rst_a = 1'b1;
    rst_b = 1'b1;
    stats_on = 1;
    step();
    chk("first_DrawX", 32'(if_a.DrawX), 32'd0);
    chk("first_DrawY", 32'(if_a.DrawY), 32'd0);
    chk("first_blank", 32'(if_a.blank), 32'd1);
    chk("first_frame_start", 32'(if_a.frame_start), 32'd1);
    chk("first_line_start", 32'(if_a.line_start), 32'd1);

    // Line 0 plus line 1 up to DrawX = 700 on the full-size instance.
    while (ka < 1501) step();
    stats_on = 0;
    chk("line_blank_cycles", 32'(a_blank_n), 32'd640);
    chk("line_hsync_cycles", 32'(a_hs_n), 32'd96);
    chk("hsync_first_x", 32'(a_hs_first), 32'd656);
    chk("hsync_last_x", 32'(a_hs_last), 32'd751);
    chk("line1_DrawY", 32'(if_a.DrawY), 32'd1);
    chk("frame_vsync_cycles", 32'(b_vs_n), 32'(2 * 32));
    chk("frame_start_count", 32'(b_fs_q.size()), 32'd3);
    if (b_fs_q.size() == 3) begin
      chk("frame_start_period1", 32'(b_fs_q[1] - b_fs_q[0]), 32'(BFT));
      chk("frame_start_period2", 32'(b_fs_q[2] - b_fs_q[1]), 32'(BFT));
    end
`ifdef VGA_FRAME_COUNT_EN
    if (b_fc_q.size() == 3) begin
      chk("fcnt_at_fs0", 32'(b_fc_q[0]), 32'd0);
      chk("fcnt_at_fs1", 32'(b_fc_q[1]), 32'd1);
      chk("fcnt_at_fs2", 32'(b_fc_q[2]), 32'd2);
    end
`endif

    chk("A_hsync_low_at_700", 32'(if_a.hsync), 32'd0);
    async_rst(1'b1, 2);

    // Walk the small instance into the region where both syncs are low.
    found = 0;
    for (int i = 0; i < 800 && !found; i++) begin
      step();
      m = mB(kb);
      if (!m[3] && !m[2]) found = 1;
    end
    chk("B_seek_both_sync", 32'(found), 32'd1);
    chk("B_pre_hsync", 32'(if_b.hsync), 32'd0);
    chk("B_pre_vsync", 32'(if_b.vsync), 32'd0);
    async_rst(1'b0, 3);
    step();
    step();
    rst_a = 1'b1;
    rst_b = 1'b1;
    step();
    chk("A_restart", 32'({if_a.DrawX, if_a.DrawY, if_a.frame_start}), 32'd1);
    chk("B_restart", 32'({if_b.DrawX, if_b.DrawY, if_b.frame_start}), 32'd1);

    // Random run lengths and reset points on either instance.
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(20, 700)) step();
      async_rst(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      repeat ($urandom_range(1, 3)) step();
      rst_a = 1'b1;
      rst_b = 1'b1;
    end
    repeat (700) step();

`ifdef VGA_FRAME_COUNT_EN
    fc_track = 0;
    force dut_b.frame_cnt_q = 16'hFFFF;
    step();
    release dut_b.frame_cnt_q;
    found = 0;
    for (int i = 0; i < int'(BFT) + 4 && !found; i++) begin
      step();
      if (if_b.frame_start) found = 1;
    end
    chk("fcnt_wrap_seen_fs", 32'(found), 32'd1);
    chk("fcnt_wrap", 32'(if_b.frame_count), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
